// File: rtl/draw_rectangle_stream.sv
// Streams the (x, y) pixel coordinates of a filled or outline rectangle over a
// valid/ready handshake; the scan order is fixed at elaboration by COL_MAJOR.
module draw_rectangle_stream #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned COL_MAJOR = 0
) (
   input  logic                    _clock,
   input  logic                    _reset_n,
   input  logic                    _start,
   input  logic signed [WIDTH-1:0] s_x,
   input  logic signed [WIDTH-1:0] s_y,
   input  logic signed [WIDTH-1:0] width,
   input  logic signed [WIDTH-1:0] height,
   input  logic                    mode,
   input  logic                    _ready,
   output logic                    _valid,
   output logic signed [WIDTH-1:0] _out0,
   output logic signed [WIDTH-1:0] _out1,
   output logic                    _busy,
   output logic                    _done
);

   localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [1:0] {IDLE, EMIT, FINISH} state_t;

   state_t                  state;
   logic signed [WIDTH-1:0] org_x, org_y, size_w, size_h;
   logic                    outline;
   logic signed [WIDTH-1:0] cnt_i, cnt_j;

   logic signed [WIDTH-1:0] fast, slow, fast_lim, slow_lim;
   logic signed [WIDTH-1:0] next_fast, next_slow, next_i, next_j;
   logic                    fast_last, slow_last, slow_edge, last_px;
   logic                    empty_req;

   assign empty_req = width[WIDTH-1] || (width == '0) || height[WIDTH-1] || (height == '0);

   // Advance the fast index; outline mode jumps across interior lines in one step.
   always_comb begin
      fast      = (COL_MAJOR != 0) ? cnt_j  : cnt_i;
      slow      = (COL_MAJOR != 0) ? cnt_i  : cnt_j;
      fast_lim  = (COL_MAJOR != 0) ? size_h : size_w;
      slow_lim  = (COL_MAJOR != 0) ? size_w : size_h;
      fast_last = (fast == fast_lim - ONE);
      slow_last = (slow == slow_lim - ONE);
      slow_edge = (slow == '0) || slow_last;
      last_px   = fast_last && slow_last;
      next_fast = fast + ONE;
      next_slow = slow;
      if (fast_last) begin
         next_fast = '0;
         next_slow = slow + ONE;
      end else if (outline && !slow_edge && (fast == '0)) begin
         next_fast = fast_lim - ONE;
      end
      next_i = (COL_MAJOR != 0) ? next_slow : next_fast;
      next_j = (COL_MAJOR != 0) ? next_fast : next_slow;
   end

   always_ff @(posedge _clock or negedge _reset_n) begin
      if (!_reset_n) begin
         state   <= IDLE;
         org_x   <= '0;
         org_y   <= '0;
         size_w  <= '0;
         size_h  <= '0;
         outline <= 1'b0;
         cnt_i   <= '0;
         cnt_j   <= '0;
         _valid  <= 1'b0;
         _out0   <= '0;
         _out1   <= '0;
         _busy   <= 1'b0;
         _done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (_start) begin
                  org_x   <= s_x;
                  org_y   <= s_y;
                  size_w  <= width;
                  size_h  <= height;
                  outline <= mode;
                  cnt_i   <= '0;
                  cnt_j   <= '0;
                  _done   <= 1'b0;
                  _busy   <= 1'b1;
                  if (empty_req) begin
                     state <= FINISH;
                  end else begin
                     state  <= EMIT;
                     _valid <= 1'b1;
                     _out0  <= s_x;
                     _out1  <= s_y;
                  end
               end
            end
            EMIT: begin
               if (_ready) begin
                  if (last_px) begin
                     _valid <= 1'b0;
                     state  <= FINISH;
                  end else begin
                     cnt_i <= next_i;
                     cnt_j <= next_j;
                     _out0 <= org_x + next_i;
                     _out1 <= org_y + next_j;
                  end
               end
            end
            FINISH: begin
               _done <= 1'b1;
               _busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_draw_rectangle_stream.sv
// Directed, table-driven bench for draw_rectangle_stream: a row-major 32-bit
// instance and a column-major 8-bit instance, plus reset and back-pressure sequences.
module tb_draw_rectangle_stream;

   logic clk, rst_n;

   logic                start0, mode0, ready0, valid0, busy0, done0;
   logic signed [31:0]  sx0, sy0, w0, h0, ox0, oy0;
   logic                start1, mode1, ready1, valid1, busy1, done1;
   logic signed [7:0]   sx1, sy1, w1, h1, ox1, oy1;

   draw_rectangle_stream #(.WIDTH(32), .COL_MAJOR(0)) dut0 (
      ._clock(clk), ._reset_n(rst_n), ._start(start0), .s_x(sx0), .s_y(sy0),
      .width(w0), .height(h0), .mode(mode0), ._ready(ready0), ._valid(valid0),
      ._out0(ox0), ._out1(oy0), ._busy(busy0), ._done(done0));

   draw_rectangle_stream #(.WIDTH(8), .COL_MAJOR(1)) dut1 (
      ._clock(clk), ._reset_n(rst_n), ._start(start1), .s_x(sx1), .s_y(sy1),
      .width(w1), .height(h1), .mode(mode1), ._ready(ready1), ._valid(valid1),
      ._out0(ox1), ._out1(oy1), ._busy(busy1), ._done(done1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit sel;   // 0 = dut0, 1 = dut1
      bit md;
      bit bp;    // ready pattern 1,0,0,1,0,0...
      bit junk;  // pulse _start with other values mid-frame
      int sx, sy, w, h, n, base;
   } vec_t;

   vec_t tbl[$];
   int   exp_x[$], exp_y[$];
   int   nvec = 0, nerr = 0;

   function automatic void add_vec(bit sel, bit md, bit bp, bit junk,
                                   int sx, int sy, int w, int h, int n);
      vec_t v;
      v.sel = sel; v.md = md; v.bp = bp; v.junk = junk;
      v.sx = sx; v.sy = sy; v.w = w; v.h = h; v.n = n; v.base = exp_x.size();
      tbl.push_back(v);
   endfunction

   function automatic void px(int x, int y);
      exp_x.push_back(x);
      exp_y.push_back(y);
   endfunction

   task automatic chk(input string nm, input int act, input int req);
      nvec++;
      if (act != req) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   task automatic sample(input bit sel, output logic vld, output logic bsy,
                         output logic dn, output int x, output int y);
      if (sel) begin
         vld = valid1; bsy = busy1; dn = done1; x = int'(ox1); y = int'(oy1);
      end else begin
         vld = valid0; bsy = busy0; dn = done0; x = int'(ox0); y = int'(oy0);
      end
   endtask

   task automatic run_frame(input vec_t v);
      int   k = 0, lastc = 0, donec = -1, x, y;
      logic vld, bsy, dn, rdy;
      @(negedge clk);
      if (v.sel) begin
         start1 = 1'b1; sx1 = 8'(v.sx); sy1 = 8'(v.sy); w1 = 8'(v.w); h1 = 8'(v.h);
         mode1 = v.md;
      end else begin
         start0 = 1'b1; sx0 = v.sx; sy0 = v.sy; w0 = v.w; h0 = v.h; mode0 = v.md;
      end
      for (int c = 0; c < 200; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 1) begin start0 = 1'b0; start1 = 1'b0; end
         if (v.junk && c == 2) begin
            if (v.sel) begin start1 = 1'b1; sx1 = 8'd99; w1 = 8'd1; mode1 = ~v.md; end
            else begin start0 = 1'b1; sx0 = 999; w0 = 1; mode0 = ~v.md; end
         end
         if (v.junk && c == 3) begin start0 = 1'b0; start1 = 1'b0; end
         rdy = (c == 0 || !v.bp) ? 1'b1 : ((c - 1) % 3 == 0);
         if (v.sel) ready1 = rdy; else ready0 = rdy;
         sample(v.sel, vld, bsy, dn, x, y);
         if (c == 1) chk("busy_after_start", int'(bsy), 1);
         if (c >= 1 && k < v.n) chk("valid_held", int'(vld), 1);
         if (vld) begin
            if (k < v.n) begin
               chk("pixel_x", x, exp_x[v.base + k]);
               chk("pixel_y", y, exp_y[v.base + k]);
            end else begin
               chk("extra_beat", k, v.n - 1);
            end
         end
         if (vld && rdy && k < v.n) begin
            k++;
            lastc = c;
         end
         if (dn && c > 0) begin
            donec = c;
            chk("busy_at_done", int'(bsy), 0);
            chk("valid_at_done", int'(vld), 0);
            break;
         end
      end
      chk("beat_count", k, v.n);
      chk("done_latency", donec, lastc + 2);
      repeat (2) @(negedge clk);
      sample(v.sel, vld, bsy, dn, x, y);
      chk("done_hold", int'(dn), 1);
      chk("busy_idle", int'(bsy), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start0 = 1'b0; mode0 = 1'b0; ready0 = 1'b0; sx0 = '0; sy0 = '0; w0 = '0; h0 = '0;
      start1 = 1'b0; mode1 = 1'b0; ready1 = 1'b0; sx1 = '0; sy1 = '0; w1 = '0; h1 = '0;

      add_vec(0, 0, 0, 1, 10, 20, 3, 2, 6);
      px(10,20); px(11,20); px(12,20); px(10,21); px(11,21); px(12,21);
      add_vec(0, 1, 0, 0, 0, 0, 3, 3, 8);
      px(0,0); px(1,0); px(2,0); px(0,1); px(2,1); px(0,2); px(1,2); px(2,2);
      add_vec(0, 0, 1, 0, -3, 7, 2, 2, 4);
      px(-3,7); px(-2,7); px(-3,8); px(-2,8);
      add_vec(0, 0, 0, 0, 1, 1, 0, 5, 0);
      add_vec(0, 0, 0, 0, 1, 1, -1, 3, 0);
      add_vec(0, 1, 0, 0, 5, -2, 4, 1, 4);
      px(5,-2); px(6,-2); px(7,-2); px(8,-2);
      add_vec(0, 1, 0, 0, 0, 0, 1, 3, 3);
      px(0,0); px(0,1); px(0,2);
      add_vec(0, 1, 0, 0, 1, 1, 4, 3, 10);
      px(1,1); px(2,1); px(3,1); px(4,1); px(1,2); px(4,2);
      px(1,3); px(2,3); px(3,3); px(4,3);
      add_vec(0, 1, 1, 0, 0, 0, 2, 2, 4);
      px(0,0); px(1,0); px(0,1); px(1,1);
      add_vec(1, 0, 0, 0, 127, 0, 2, 2, 4);
      px(127,0); px(127,1); px(-128,0); px(-128,1);
      add_vec(1, 1, 1, 0, 0, 0, 3, 3, 8);
      px(0,0); px(0,1); px(0,2); px(1,0); px(1,2); px(2,0); px(2,1); px(2,2);

      repeat (2) @(negedge clk);
      chk("rst_valid0", int'(valid0), 0);
      chk("rst_busy0",  int'(busy0),  0);
      chk("rst_done0",  int'(done0),  0);
      chk("rst_out0x",  int'(ox0),    0);
      chk("rst_out0y",  int'(oy0),    0);
      chk("rst_valid1", int'(valid1), 0);
      chk("rst_done1",  int'(done1),  0);
      rst_n = 1'b1;

      foreach (tbl[t]) run_frame(tbl[t]);

      // Abort a frame after three transfers, then rerun it from scratch.
      @(negedge clk);
      start0 = 1'b1; sx0 = 10; sy0 = 20; w0 = 3; h0 = 2; mode0 = 1'b0; ready0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_abort_x", int'(ox0), 10);
      chk("pre_abort_y", int'(oy0), 21);
      rst_n = 1'b0;
      #1;
      chk("abort_valid", int'(valid0), 0);
      chk("abort_busy",  int'(busy0),  0);
      chk("abort_done",  int'(done0),  0);
      chk("abort_x",     int'(ox0),    0);
      chk("abort_y",     int'(oy0),    0);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(tbl[0]);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/draw_rectangle_stream.md
Name: draw_rectangle_stream

Overview:
Parametrised successor of the filled-rectangle coordinate generator. On a start pulse it latches origin, width, height and mode, then streams one (x, y) pixel coordinate per accepted transfer over a valid/ready handshake. Modes are filled or outline-only, and scan order is selectable. It sits between the Python2Verilog-generated drawing front-end and the framebuffer writer, and back-pressure from the writer stalls generation without loss.

Parameters:
WIDTH, 32, signed bit width of coordinates, sizes and outputs
COL_MAJOR, 0, 0 = x varies fastest (row-major); 1 = y varies fastest (column-major)

Ports:
_clock  input  1  rising-edge clock
_reset_n  input  1  asynchronous active-low reset
_start  input  1  one-cycle request; sampled only when idle
s_x  input  WIDTH  signed origin x, latched on accepted start
s_y  input  WIDTH  signed origin y, latched on accepted start
width  input  WIDTH  signed rectangle width, latched
height  input  WIDTH  signed rectangle height, latched
mode  input  1  0 = filled, 1 = outline, latched
_ready  input  1  downstream accepts current coordinate
_valid  output  1  _out0/_out1 hold a valid coordinate
_out0  output  WIDTH  pixel x
_out1  output  WIDTH  pixel y
_busy  output  1  high from accepted start until _done rises
_done  output  1  high after the last pixel is accepted; held until next accepted start

Behaviour:
- Reset (async assert, sync release): state IDLE; _valid=0, _out0=0, _out1=0, _busy=0, _done=0; internal counters cleared. Reset mid-stream aborts immediately with no further outputs.
- States: IDLE, EMIT, FINISH.
- IDLE: _start=1 latches all inputs, clears counters, drops _done and sets _busy next cycle.
  - If width<=0 or height<=0, go to FINISH with no pixels emitted.
  - Otherwise go to EMIT with _valid=1 and the first coordinate on the next edge. Start-to-first-valid latency is 1 cycle.
- _start while _busy is ignored, and latched values are unaffected.
- EMIT: _out0 = s_x + i, _out1 = s_y + j, with 0<=i<width and 0<=j<height.
  - Sums are truncated to WIDTH bits (two's-complement wrap, no saturation).
  - Transfer occurs on a cycle with _valid & _ready. On transfer, the next coordinate is presented the following cycle, so sustained throughput is 1 pixel/cycle with _ready held high.
  - With _ready low, _valid and the outputs hold stable. _valid never drops without a transfer.
- Scan order:
  - COL_MAJOR=0: i increments fastest; at i=width-1, i wraps to 0 and j increments.
  - COL_MAJOR=1: the roles of i and j are swapped.
- Outline mode: emit only pixels with i∈{0,width-1} or j∈{0,height-1}.
  - Interior pixels are skipped with zero cycle cost: from the first edge pixel of an interior line, the fast index jumps directly to its last value.
  - Each pixel is emitted once, including when width=1 or height=1 (a single line, no duplicates).
  - Pixel count is 2w+2h-4 for w,h>=2, and w*h otherwise.
- Last pixel: its transfer moves to FINISH. _valid=0 the next cycle.
- FINISH: lasts one cycle, sets _done=1 and _busy=0, then returns to IDLE. _done stays 1 in IDLE.
- A _start in the same cycle _done is observed high is accepted normally.
- Outputs are registered; there is no combinational path from _ready to _valid or to the outputs.
- Counters are WIDTH bits and are compared against the latched width/height as signed values.

Test Plan:
- Filled, COL_MAJOR=0, s_x=10, s_y=20, w=3, h=2, _ready=1 → 6 beats (10,20),(11,20),(12,20),(10,21),(11,21),(12,21) on consecutive cycles; _done high 1 cycle after the last beat, then held.
- Outline, w=3, h=3, origin (0,0) → 8 beats (0,0),(1,0),(2,0),(0,1),(2,1),(0,2),(1,2),(2,2); (1,1) never appears; 8 cycles with _ready=1.
- Back-pressure: filled 2x2, _ready toggles 1,0,0,1,... → exactly 4 transfers, outputs stable while _ready=0, no duplicates or drops.
- Degenerate sizes: w=0,h=5 → no _valid, _done after 2 cycles; w=-1 → same; outline w=4,h=1 → 4 beats, no repeats.
- Wrap and order: WIDTH=8, COL_MAJOR=1, s_x=127, w=2, h=2 → x sequence 127,127,-128,-128, with y varying fastest.
- Reset mid-stream: assert _reset_n=0 after 3 beats → immediately _valid=0, _busy=0, _done=0, outputs 0; a new start after release runs a full frame from the beginning.
